// File: rtl/sseg_pkg.sv
// ----------------------------------------------------------------------------
// sseg_pkg
//   Shared types and constants for the seven-segment display arbiter.
//   SSEG_BLANK   : all segments off (segments are active-low)
//   sseg_digit_t : one 7-segment digit pattern
//   arb_state_t  : arbiter FSM states
// ----------------------------------------------------------------------------
package sseg_pkg;

   localparam int DIGITS     = 4;
   localparam int DIGIT_W    = 7;
   localparam int SRC_W      = DIGITS * DIGIT_W;   // bits per source in pattern_i

   typedef logic [DIGIT_W-1:0] sseg_digit_t;

   localparam sseg_digit_t SSEG_BLANK = 7'b1111111;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

endpackage : sseg_pkg

// File: rtl/sseg_display_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin search. Returns the first set bit of `req`
//   found when walking upward from index `start`, wrapping modulo NUM_REQ.
//   Ports:
//     req   in   NUM_REQ  candidate mask
//     start in   IDX_W    index where the search begins
//     valid out  1        at least one candidate was found
//     index out  IDX_W    winning index (0 when valid is low)
// ----------------------------------------------------------------------------
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   start,
   output logic               valid,
   output logic [IDX_W-1:0]   index
);

   logic [IDX_W-1:0] cand;

   // start + offset, wrapped into 0..NUM_REQ-1 (NUM_REQ need not be a power of 2)
   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int offset);
      int sum;
      sum = int'(base) + offset;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return IDX_W'(sum);
   endfunction

   // Walk offsets from farthest to nearest so the nearest hit is written last.
   always_comb begin
      valid = 1'b0;
      index = '0;
      cand  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand = wrap_add(start, i);
         if (req[cand]) begin
            valid = 1'b1;
            index = cand;
         end
      end
   end

endmodule : rr_picker

// File: rtl/sseg_display_arbiter.sv
// ----------------------------------------------------------------------------
// sseg_display_arbiter
//   Shares the 4-digit seven-segment display between NUM_REQ pattern sources
//   using round-robin arbitration with a minimum hold time per grant. The
//   granted source's digits are registered onto in0..in3; the display is
//   blanked when nobody owns it.
//   Ports:
//     clk_i      in   1            system clock
//     rst_ni     in   1            asynchronous active-low reset
//     req_i      in   NUM_REQ      per-source level request
//     pattern_i  in   NUM_REQ*28   source k digit d at [28k+7d +: 7]
//     gnt_o      out  NUM_REQ      one-hot grant, all-zero when idle
//     busy_o     out  1            a grant is active
//     in0_o..in3_o out 7           registered digit patterns (active-low)
// ----------------------------------------------------------------------------
module sseg_display_arbiter
   import sseg_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int HOLD_CYCLES = 50_000_000
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [NUM_REQ-1:0]       req_i,
   input  logic [NUM_REQ*SRC_W-1:0] pattern_i,
   output logic [NUM_REQ-1:0]       gnt_o,
   output logic                     busy_o,
   output sseg_digit_t              in0_o,
   output sseg_digit_t              in1_o,
   output sseg_digit_t              in2_o,
   output sseg_digit_t              in3_o
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   arb_state_t       state;
   logic [CNT_W-1:0] hold_cnt;
   logic [IDX_W-1:0] last_gnt;   // doubles as the current owner while in GRANT

   logic [IDX_W-1:0] start_idx;
   logic [NUM_REQ-1:0] pick_mask;
   logic             pick_valid;
   logic [IDX_W-1:0] pick_idx;
   logic             owner_req;
   logic             hold_done;

   arb_state_t       state_nxt;
   logic [IDX_W-1:0] owner_nxt;
   logic [CNT_W-1:0] hold_nxt;
   logic [NUM_REQ-1:0] gnt_nxt;

   sseg_digit_t      pat [NUM_REQ][DIGITS];
   sseg_digit_t      digit_nxt [DIGITS];

   // Unpack the flat pattern bus into [source][digit].
   for (genvar k = 0; k < NUM_REQ; k++) begin : g_src
      for (genvar d = 0; d < DIGITS; d++) begin : g_dig
         assign pat[k][d] = pattern_i[SRC_W*k + DIGIT_W*d +: DIGIT_W];
      end
   end

   // Search always begins just after the most recent owner.
   assign start_idx = (last_gnt == LAST_IDX) ? '0 : last_gnt + IDX_W'(1);
   assign owner_req = req_i[last_gnt];
   assign hold_done = (hold_cnt == HOLD_MAX);

   // While granted, the owner is excluded so a handover always picks someone
   // else; when the owner has dropped its request this changes nothing.
   always_comb begin
      pick_mask = req_i;
      if (state == GRANT) pick_mask[last_gnt] = 1'b0;
   end

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req   (pick_mask),
      .start (start_idx),
      .valid (pick_valid),
      .index (pick_idx)
   );

   // Next-state decision.
   always_comb begin
      state_nxt = state;
      owner_nxt = last_gnt;
      hold_nxt  = hold_cnt;
      unique case (state)
         IDLE: begin
            if (pick_valid) begin
               state_nxt = GRANT;
               owner_nxt = pick_idx;
               hold_nxt  = '0;
            end
         end
         GRANT: begin
            if (!owner_req) begin
               // Owner released: no hold enforced, hand over or go idle.
               hold_nxt = '0;
               if (pick_valid) owner_nxt = pick_idx;
               else            state_nxt = IDLE;
            end else if (!hold_done) begin
               hold_nxt = hold_cnt + CNT_W'(1);
            end else if (pick_valid) begin
               owner_nxt = pick_idx;
               hold_nxt  = '0;
            end
            // Hold expired with no contender: keep owner, counter stays saturated.
         end
         default: begin
            state_nxt = IDLE;
            hold_nxt  = '0;
         end
      endcase
   end

   // Output values for the next edge; grant and digits always move together.
   always_comb begin
      gnt_nxt = '0;
      for (int d = 0; d < DIGITS; d++) digit_nxt[d] = SSEG_BLANK;
      if (state_nxt == GRANT) begin
         gnt_nxt[owner_nxt] = 1'b1;
         for (int d = 0; d < DIGITS; d++) digit_nxt[d] = pat[owner_nxt][d];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         hold_cnt <= '0;
         last_gnt <= LAST_IDX;
         gnt_o    <= '0;
         busy_o   <= 1'b0;
         in0_o    <= SSEG_BLANK;
         in1_o    <= SSEG_BLANK;
         in2_o    <= SSEG_BLANK;
         in3_o    <= SSEG_BLANK;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
         last_gnt <= owner_nxt;
         gnt_o    <= gnt_nxt;
         busy_o   <= (state_nxt == GRANT);
         in0_o    <= digit_nxt[0];
         in1_o    <= digit_nxt[1];
         in2_o    <= digit_nxt[2];
         in3_o    <= digit_nxt[3];
      end
   end

endmodule : sseg_display_arbiter

// File: tb/tb_sseg_display_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sseg_display_arbiter
//   Self-checking bench for sseg_display_arbiter (NUM_REQ=4, HOLD_CYCLES=4).
//   A behavioural ownership model tracks who owns the display and for how
//   many cycles; a compare process checks every output on every falling edge.
//   Directed sequences add hand-computed literal expectations, followed by a
//   randomized request/pattern/reset phase.
// ----------------------------------------------------------------------------
module tb_sseg_display_arbiter;

   localparam int N = 4;
   localparam int H = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req = '0;
   logic [N*28-1:0] pattern = '0;
   logic [N-1:0]  gnt;
   logic          busy;
   logic [6:0]    in0, in1, in2, in3;

   int checks = 0;
   int failures = 0;

   // model state: owner (-1 = nobody), cycles owned so far, most recent owner
   int m_owner = -1;
   int m_held  = 0;
   int m_last  = N - 1;
   int m_win;
   logic [N-1:0] m_others;
   logic [N-1:0] exp_gnt = '0;
   logic [6:0]   exp_dig [4] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};

   sseg_display_arbiter #(
      .NUM_REQ     (N),
      .HOLD_CYCLES (H)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .req_i     (req),
      .pattern_i (pattern),
      .gnt_o     (gnt),
      .busy_o    (busy),
      .in0_o     (in0),
      .in1_o     (in1),
      .in2_o     (in2),
      .in3_o     (in3)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic int rr(input logic [N-1:0] mask, input int start);
      for (int i = 0; i < N; i++) begin
         if (mask[(start + i) % N]) return (start + i) % N;
      end
      return -1;
   endfunction

   task automatic set_dig(input int k, input int d, input logic [6:0] v);
      pattern[28*k + 7*d +: 7] = v;
   endtask

   // Behavioural model: who owns the display after each edge.
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_owner = -1;
         m_held  = 0;
         m_last  = N - 1;
      end else begin
         if (m_owner < 0) begin
            m_win = rr(req, (m_last + 1) % N);
            if (m_win >= 0) begin
               m_owner = m_win;
               m_held  = 1;
            end
         end else if (!req[m_owner]) begin
            m_win   = rr(req, (m_owner + 1) % N);
            m_owner = m_win;
            m_held  = (m_win >= 0) ? 1 : 0;
         end else if (m_held < H) begin
            m_held++;
         end else begin
            m_others = req;
            m_others[m_owner] = 1'b0;
            m_win = rr(m_others, (m_owner + 1) % N);
            if (m_win >= 0) begin
               m_owner = m_win;
               m_held  = 1;
            end
         end
         if (m_owner >= 0) m_last = m_owner;
      end
      exp_gnt = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      for (int d = 0; d < 4; d++)
         exp_dig[d] = (m_owner >= 0) ? pattern[28*m_owner + 7*d +: 7] : 7'h7F;
   end

   // Compare process: every falling edge.
   initial forever begin
      @(negedge clk);
      chk("gnt",  32'(gnt),  32'(exp_gnt));
      chk("busy", 32'(busy), 32'(exp_gnt != '0));
      chk("in0",  32'(in0),  32'(exp_dig[0]));
      chk("in1",  32'(in1),  32'(exp_dig[1]));
      chk("in2",  32'(in2),  32'(exp_dig[2]));
      chk("in3",  32'(in3),  32'(exp_dig[3]));
   end

   task automatic tick();
      @(negedge clk);
   endtask

   // Asynchronous reset pulse between clock edges; outputs must blank at once.
   task automatic pulse_reset();
      #1 rst_n = 1'b0;
      #1;
      chk("async_gnt",  32'(gnt),  32'h0);
      chk("async_busy", 32'(busy), 32'h0);
      chk("async_in0",  32'(in0),  32'h7F);
      chk("async_in3",  32'(in3),  32'h7F);
      rst_n = 1'b1;
   endtask

   logic [3:0] exp2 [9] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h4, 4'h4, 4'h4, 4'h4, 4'h1};

   initial begin
      // source k digit d = 16k + d + 1
      for (int k = 0; k < N; k++)
         for (int d = 0; d < 4; d++) set_dig(k, d, 7'(16*k + d + 1));

      // Reset held with all requests asserted
      req = 4'b1111;
      repeat (3) begin
         tick();
         chk("rst_gnt", 32'(gnt), 32'h0);
         chk("rst_in0", 32'(in0), 32'h7F);
      end
      rst_n = 1'b1;
      tick();
      chk("first_gnt", 32'(gnt), 32'h1);
      chk("first_in0", 32'(in0), 32'h01);

      // Hold and rotate between sources 0 and 2
      req = 4'b0101;
      pulse_reset();
      for (int i = 0; i < 9; i++) begin
         tick();
         chk("rot_gnt", 32'(gnt), 32'(exp2[i]));
         chk("rot_in0", 32'(in0), (exp2[i] == 4'h1) ? 32'h01 : 32'h21);
      end

      // Early drop with handover, then drop with nothing pending
      req = 4'b0101;
      pulse_reset();
      tick();
      chk("drop_gnt0", 32'(gnt), 32'h1);
      req = 4'b0100;
      tick();
      chk("drop_handover", 32'(gnt), 32'h4);
      chk("drop_busy", 32'(busy), 32'h1);
      req = 4'b0000;
      tick();
      chk("drop_idle_gnt", 32'(gnt), 32'h0);
      chk("drop_idle_busy", 32'(busy), 32'h0);
      chk("drop_idle_in0", 32'(in0), 32'h7F);

      // Sole requester keeps the display; late contender wins immediately
      req = 4'b0010;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("sole_gnt", 32'(gnt), 32'h2);
      end
      req = 4'b1010;
      tick();
      chk("late_gnt", 32'(gnt), 32'h8);

      // Wrap from last owner 3 to index 0; pattern change on the owner
      req = 4'b0000;
      tick();
      chk("wrap_idle", 32'(gnt), 32'h0);
      req = 4'b1001;
      tick();
      chk("wrap_gnt", 32'(gnt), 32'h1);
      set_dig(0, 0, 7'h55);
      tick();
      chk("pat_update", 32'(in0), 32'h55);

      // Asynchronous reset mid-grant
      pulse_reset();
      tick();
      chk("post_rst_gnt", 32'(gnt), 32'h1);

      // Randomized phase
      for (int k = 0; k < N; k++)
         for (int d = 0; d < 4; d++) set_dig(k, d, 7'($urandom_range(0, 127)));
      for (int c = 0; c < 3000; c++) begin
         tick();
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
         if ($urandom_range(0, 9) == 0)
            set_dig($urandom_range(0, N-1), $urandom_range(0, 3), 7'($urandom_range(0, 127)));
         if ($urandom_range(0, 199) == 0) pulse_reset();
      end

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_sseg_display_arbiter
